// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared widths, op codes and state encodings for the mul/div sequencer.
package muldiv_pkg;
    localparam int XLEN = 32;
    localparam int ITER = 32;
    localparam int CW   = $clog2(ITER);
    localparam int AW   = 2*XLEN+1;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration -- shift-add for multiply, restoring trial-subtract for divide.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic [AW-1:0]   acc,
    input  logic [XLEN-1:0] opnd,
    input  logic            div,
    output logic [AW-1:0]   acc_n
);
    logic [XLEN:0]   sum;
    logic [XLEN+1:0] diff;
    always_comb begin
        sum   = acc[AW-1:XLEN] + {1'b0, acc[0] ? opnd : {XLEN{1'b0}}};
        diff  = {1'b0, acc[AW-2:XLEN-1]} - {2'b00, opnd};
        acc_n = div ? (diff[XLEN+1] ? {acc[AW-2:0], 1'b0} : {diff[XLEN:0], acc[XLEN-2:0], 1'b1})
                    : {1'b0, sum, acc[XLEN-1:1]};
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO owner and sequencer for MULT/MULTU/DIV/DIVU, fixed 34-cycle latency by default.
// Define MULDIV_EARLY_OUT_EN to let multiplies finish once the remaining multiplier bits are zero.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    input  logic            hilo_read,
    input  logic [1:0]      hilo_we,
    input  logic [XLEN-1:0] hilo_wdata,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     acc_q, acc_d, acc_n;
    logic [XLEN-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d, ma, mb;
    logic              div_q, div_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, sgn;
    logic [2*XLEN-1:0] prod;
`ifdef MULDIV_EARLY_OUT_EN
    logic [XLEN-1:0]   rem_mask;
    assign rem_mask = {XLEN{1'b1}} >> ({1'b0, count_q} + 1'b1);
`endif

    muldiv_step u_step (.acc(acc_q), .opnd(opnd_q), .div(div_q), .acc_n(acc_n));

    always_comb begin
        sgn       = ~op[0];
        ma        = mag(opa, sgn);
        mb        = mag(opb, sgn);
        prod      = neg_quo_q ? -acc_q[2*XLEN-1:0] : acc_q[2*XLEN-1:0];
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        div_d     = div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (state_q == S_IDLE && start) begin
            state_d   = S_RUN;
            count_d   = '0;
            div_d     = op[1];
            acc_d     = {{(XLEN+1){1'b0}}, op[1] ? ma : mb};
            opnd_d    = op[1] ? mb : ma;
            neg_quo_d = sgn & (opa[XLEN-1] ^ opb[XLEN-1]);
            neg_rem_d = sgn & opa[XLEN-1];
        end else if (state_q == S_IDLE) begin
            hi_d = hilo_we[1] ? hilo_wdata : hi_q;
            lo_d = hilo_we[0] ? hilo_wdata : lo_q;
        end else if (state_q == S_RUN) begin
            acc_d   = acc_n;
            count_d = count_q + 1'b1;
            state_d = (count_q == CW'(ITER-1)) ? S_FIX : S_RUN;
`ifdef MULDIV_EARLY_OUT_EN
            // remaining iterations would only shift right; do the shift in one go
            if (!div_q && (acc_n[XLEN-1:0] & rem_mask) == '0) begin
                acc_d   = acc_n >> (CW'(ITER-1) - count_q);
                state_d = S_FIX;
            end
`endif
        end else begin
            state_d = S_IDLE;
            hi_d    = div_q ? (neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN]) : prod[2*XLEN-1:XLEN];
            lo_d    = div_q ? (neg_quo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]) : prod[XLEN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            div_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            div_q     <= div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy  = state_q != S_IDLE;
    assign stall = busy & (start | hilo_read | (|hilo_we));
    assign done  = state_q == S_FIX;
    assign hi    = hi_q;
    assign lo    = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed and randomized checks of muldiv_ctrl against a cycle-level behavioural model.
module tb_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        reset, start, hilo_read, busy, stall, done;
    logic [1:0]  op, hilo_we;
    logic [31:0] opa, opb, hilo_wdata, hi, lo;
    int          tests = 0, fails = 0, cyc = 0;
    int          m_rem = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_pend = '0;

    always #5 clk = ~clk;

    muldiv_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
        .hilo_read(hilo_read), .hilo_we(hilo_we), .hilo_wdata(hilo_wdata),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // {HI, LO} an operation must produce, straight from the arithmetic definition
    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (o)
            2'b00: return 64'(longint'(sa) * longint'(sb));
            2'b01: return {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 0) return {a, a[31] ? 32'h1 : 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

`ifdef MULDIV_EARLY_OUT_EN
    function automatic int early_busy(input logic [1:0] o, input logic [31:0] b);
        logic [31:0] mb;
        int k;
        mb = (o == 2'b00 && b[31]) ? -b : b;
        k = 1;
        while (k < 32 && (mb >> k) != 0) k++;
        return k + 1;
    endfunction
`endif

    // compare mid-cycle, then advance the model across the coming edge
    task automatic tick();
        logic eb;
        @(negedge clk);
        eb = m_rem > 0;
        check("busy", busy, eb);
        check("done", done, m_rem == 1);
        check("stall", stall, eb & (start | hilo_read | (|hilo_we)));
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        if (reset) begin
            m_rem = 0; m_hi = '0; m_lo = '0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) {m_hi, m_lo} = m_pend;
        end else if (start) begin
            m_rem  = 33;
            m_pend = ref_res(op, opa, opb);
`ifdef MULDIV_EARLY_OUT_EN
            if (!op[1]) m_rem = early_busy(op, opb);
`endif
        end else begin
            if (hilo_we[1]) m_hi = hilo_wdata;
            if (hilo_we[0]) m_lo = hilo_wdata;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int n, output int dn);
        start = 1'b1; op = o; opa = a; opb = b;
        tick();
        start = 1'b0;
        n = 0; dn = -1;
        while (busy && n < 100) begin
            n++;
            if (done) dn = n;
            tick();
        end
        if (n >= 100) check("run_timeout", n, 0);
    endtask

    task automatic wait_stall(output int n);
        #1;
        n = 0;
        while (stall && n < 100) begin
            n++;
            tick();
            #1;
        end
        if (n >= 100) check("stall_timeout", n, 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n, dn, k;
        logic held;
        reset = 1'b1; start = 1'b0; hilo_read = 1'b0; hilo_we = 2'b00;
        op = 2'b00; opa = '0; opb = '0; hilo_wdata = '0;
        @(posedge clk);
        #1;
        tick();
        reset = 1'b0;
        check("reset_hi", hi, 32'h0);
        check("reset_busy", busy, 1'b0);

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, n, dn);
        check("multu_ff_hi", hi, 32'hFFFFFFFE);
        check("multu_ff_lo", lo, 32'h00000001);
`ifndef MULDIV_EARLY_OUT_EN
        check("multu_busy_cycles", n, 33);
        check("multu_done_cycle", dn, 33);
`endif
        run_op(2'b00, 32'hFFFFFFFD, 32'd5, n, dn);
        check("mult_neg_hi", hi, 32'hFFFFFFFF);
        check("mult_neg_lo", lo, 32'hFFFFFFF1);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, n, dn);
        check("div_neg_lo", lo, 32'hFFFFFFFD);
        check("div_neg_hi", hi, 32'hFFFFFFFF);
        check("div_busy_cycles", n, 33);
        run_op(2'b11, 32'h1234, 32'h0, n, dn);
        check("divu_zero_lo", lo, 32'hFFFFFFFF);
        check("divu_zero_hi", hi, 32'h00001234);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, n, dn);
        check("div_ovf_lo", lo, 32'h80000000);
        check("div_ovf_hi", hi, 32'h0);

        start = 1'b1; op = 2'b01; opa = 32'd6; opb = 32'd7;
        tick();
        start = 1'b0;
        tick();
        hilo_read = 1'b1;
        wait_stall(n);
`ifndef MULDIV_EARLY_OUT_EN
        check("read_stall_cycles", n, 32);
`endif
        check("read_lo", lo, 32'd42);
        hilo_read = 1'b0;
        tick();

        start = 1'b1; op = 2'b01; opa = 32'd3; opb = 32'd5;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1; op = 2'b11; opa = 32'd100; opb = 32'd7;
        wait_stall(n);
`ifndef MULDIV_EARLY_OUT_EN
        check("start_stall_cycles", n, 29);
`endif
        check("first_lo", lo, 32'd15);
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin n++; tick(); end
        check("second_busy", n, 33);
        check("second_hi", hi, 32'd2);
        check("second_lo", lo, 32'd14);

        hilo_we = 2'b10; hilo_wdata = 32'hDEADBEEF;
        #1;
        check("mthi_idle_stall", stall, 1'b0);
        tick();
        hilo_we = 2'b00;
        check("mthi_hi", hi, 32'hDEADBEEF);
        check("mthi_lo", lo, 32'd14);
        start = 1'b1; op = 2'b01; opa = 32'd2; opb = 32'd3;
        tick();
        start = 1'b0;
        hilo_we = 2'b01; hilo_wdata = 32'hCAFEF00D;
        wait_stall(n);
`ifndef MULDIV_EARLY_OUT_EN
        check("mtlo_stall_cycles", n, 33);
`endif
        check("mtlo_pre_lo", lo, 32'd6);
        tick();
        hilo_we = 2'b00;
        check("mtlo_hi", hi, 32'h0);
        check("mtlo_lo", lo, 32'hCAFEF00D);

        start = 1'b1; op = 2'b10; opa = 32'hFFFFFFF9; opb = 32'd2;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        run_op(2'b10, 32'd100, 32'hFFFFFFF9, n, dn);
        check("after_abort_lo", lo, 32'hFFFFFFF2);
        check("after_abort_hi", hi, 32'd2);

        repeat (250) begin
            k = $urandom_range(0, 99);
            start = 1'b0; hilo_read = 1'b0; hilo_we = 2'b00; reset = 1'b0;
            if (k < 40) begin
                start = 1'b1; op = 2'($urandom); opa = pick(); opb = pick();
            end else if (k < 55) begin
                hilo_we = 2'($urandom_range(1, 3)); hilo_wdata = $urandom;
            end else if (k < 75) begin
                hilo_read = 1'b1;
            end else if (k < 77) begin
                reset = 1'b1;
            end
            held = 1'b1;
            n = 0;
            while (held && n < 100) begin
                held = (m_rem > 0) && (start | hilo_read | (|hilo_we));
                n++;
                tick();
            end
        end
        start = 1'b0; hilo_read = 1'b0; hilo_we = 2'b00; reset = 1'b0;
        repeat (40) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
